perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width in bits (2..64).
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent counter channels (1..16).
REQ-003 SHALL have parameter SATURATE, default 0: 0 means wrap at overflow, 1 means hold at all-ones.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port ch_en, input, NUM_CH, per-channel count enable.
REQ-007 SHALL have port event_in, input, NUM_CH, per-channel increment request.
REQ-008 SHALL have port clr_all, input, 1, synchronous clear of all counters and overflow flags.
REQ-009 SHALL have port wr_en, input, 1, preload strobe.
REQ-010 SHALL have port wr_ch, input, $clog2(NUM_CH) (min 1), preload channel index.
REQ-011 SHALL have port wr_data, input, WIDTH, preload value.
REQ-012 SHALL have port rd_en, input, 1, read request.
REQ-013 SHALL have port rd_ch, input, $clog2(NUM_CH) (min 1), read channel index.
REQ-014 SHALL have port rd_data, output, WIDTH, registered read data.
REQ-015 SHALL have port rd_valid, output, 1, high one cycle when rd_data is updated.
REQ-016 SHALL have port ovf, output, NUM_CH, sticky per-channel overflow flags.
REQ-017 SHALL have port ovf_clr, input, NUM_CH, per-channel overflow flag clear.

Function
REQ-018 SHALL increment channel i by 1 on each clk edge where ch_en[i] and event_in[i] are both high.
REQ-019 SHALL, in wrap mode, take all-ones + 1 to 0 and set ovf[i].
REQ-020 SHALL, in saturate mode, hold all-ones on increment and set ovf[i] on every attempted increment at all-ones.
REQ-021 SHALL load wr_data into channel wr_ch on wr_en; the load overrides any same-cycle increment of that channel only.
REQ-022 SHALL give clr_all priority over wr_en and increment; counters and ovf go to 0 on the next edge.
REQ-023 SHALL set ovf[i] when an overflow coincides with ovf_clr[i] (set wins); otherwise ovf_clr[i] clears it.
REQ-024 SHALL present, on rd_en, the counter value from before that edge's update on rd_data one cycle later, with rd_valid high for exactly that cycle.
REQ-025 SHALL return 0 with rd_valid high for rd_ch >= NUM_CH, and SHALL ignore wr_en for wr_ch >= NUM_CH.
REQ-026 SHALL hold rd_data between reads; rd_valid SHALL be low when rd_en was low.

Reset
REQ-027 SHALL, on reset asserted, clear immediately and asynchronously: all counters to 0, ovf to 0, rd_data to 0, rd_valid to 0.
REQ-028 SHALL abandon an in-flight read on reset; no rd_valid pulse follows a reset.

Configuration
REQ-029 SHALL, with macro PERF_COUNTER_SNAPSHOT_EN defined, add input snap (1 bit) and input rd_snap (1 bit).
REQ-030 SHALL, with snapshot enabled, copy all counters on snap into shadow registers; values are taken before that edge's update; shadows reset to 0; clr_all does not clear them.
REQ-031 SHALL, with snapshot enabled, read the shadow register instead of the live counter when rd_snap is high with rd_en.
REQ-032 SHALL, without the macro, have no snap or rd_snap ports and no shadow storage.

Structure
REQ-033 SHALL place in shared package perf_counter_pkg: the max-channel constant (16) and the saturate/wrap mode enumeration.
REQ-034 SHALL implement each channel in sub-module perf_counter_channel (counter, ovf flag, preload, clear), instantiated NUM_CH times.

Verification
REQ-035 SHALL test with WIDTH=8, NUM_CH=4: ch_en=4'b0101, event_in=4'b1111 for 10 cycles -> channels 0 and 2 read 10; channels 1 and 3 read 0.
REQ-036 SHALL test with WIDTH=8, SATURATE=0: preload ch1=0xFE, then 3 events -> ch1=0x01, ovf[1]=1; ovf_clr[1] -> ovf[1]=0.
REQ-037 SHALL test with WIDTH=8, SATURATE=1: preload ch2=0xFF, then 2 events -> ch2=0xFF, ovf[2]=1.
REQ-038 SHALL test wr_en ch0=0x40 with a same-cycle event on ch0 -> 0x40; the same cycle with clr_all -> 0x00.
REQ-039 SHALL test rd_en ch3 with value 5 and a same-cycle event -> next cycle rd_data=5, rd_valid=1; a following read returns 6.
REQ-040 SHALL test: count ch0 to 7, assert reset mid-read -> rd_valid stays 0 and all outputs are 0; with PERF_COUNTER_SNAPSHOT_EN, snap at 7 then 3 more events -> snapshot read 7, live read 10.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Shared definitions for the performance counter bank: channel limit and counting mode.
package perf_counter_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic {
      MODE_WRAP     = 1'b0,
      MODE_SATURATE = 1'b1
   } count_mode_e;

endpackage

// File: rtl/perf_counter_channel.sv
// One counter channel: counter register, sticky overflow flag, preload and synchronous clear.
module perf_counter_channel
   import perf_counter_pkg::*;
#(
   parameter int          WIDTH = 32,
   parameter count_mode_e MODE  = MODE_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] loadData_i,
   input  logic             inc_i,
   input  logic             ovfClr_i,
   output logic [WIDTH-1:0] count_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Clear beats preload, preload beats increment; an overflow sets the flag even against ovfClr_i
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q & ~ovfClr_i;
      if (clr_i) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load_i) begin
         count_d = loadData_i;
      end else if (inc_i) begin
         if (&count_q) begin
            ovf_d   = 1'b1;
            count_d = (MODE == MODE_SATURATE) ? count_q : '0;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with preload, registered readback and sticky overflow flags.
// Defining PERF_COUNTER_SNAPSHOT_EN adds snap/rd_snap ports and a shadow copy of every counter.
module perf_counter_bank
   import perf_counter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM_CH   = 4,
   parameter int SATURATE = 0,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] event_in,
   input  logic              clr_all,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [NUM_CH-1:0] ovf_clr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic [NUM_CH-1:0] ovf
`ifdef PERF_COUNTER_SNAPSHOT_EN
   ,
   input  logic              snap,
   input  logic              rd_snap
`endif
);

   localparam count_mode_e MODE = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;

   logic [WIDTH-1:0] cnt [NUM_CH];
   logic [WIDTH-1:0] readSel;
   logic [WIDTH-1:0] rdData_q, rdData_d;
   logic             rdValid_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
      perf_counter_channel #(
         .WIDTH (WIDTH),
         .MODE  (MODE)
      ) uChannel (
         .clk        (clk),
         .reset      (reset),
         .clr_i      (clr_all),
         .load_i     (wr_en && (wr_ch == CH_W'(i))),
         .loadData_i (wr_data),
         .inc_i      (ch_en[i] & event_in[i]),
         .ovfClr_i   (ovf_clr[i]),
         .count_o    (cnt[i]),
         .ovf_o      (ovf[i])
      );
   end

`ifdef PERF_COUNTER_SNAPSHOT_EN
   logic [WIDTH-1:0] shadow_q [NUM_CH];

   // Shadows capture pre-update counter values and deliberately survive clr_all
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      end else if (snap) begin
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= cnt[i];
      end
   end

   always_comb begin
      readSel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) readSel = rd_snap ? shadow_q[i] : cnt[i];
      end
   end
`else
   // An index with no matching channel leaves readSel at zero
   always_comb begin
      readSel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) readSel = cnt[i];
      end
   end
`endif

   assign rdData_d = rd_en ? readSel : rdData_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         rdData_q  <= rdData_d;
         rdValid_q <= rd_en;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: a wrap-mode and a saturate-mode bank share stimulus and are compared to a behavioural model.
module tb_perf_counter_bank;

`ifdef PERF_COUNTER_SNAPSHOT_EN
   localparam bit SNAP_EN = 1'b1;
`else
   localparam bit SNAP_EN = 1'b0;
`endif
   localparam int MAXV = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ch_en, event_in, ovf_clr;
   logic       clr_all, wr_en, rd_en, snap, rd_snap;
   logic [1:0] wr_ch, rd_ch;
   logic [7:0] wr_data;

   logic [7:0] rdDataW, rdDataS;
   logic       rdValidW, rdValidS;
   logic [3:0] ovfW, ovfS;

   int mCnt [2][4];
   bit mOvf [2][4];
   int mShadow [2][4];
   int expRd [2];
   bit expRv;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   perf_counter_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(0)) dutWrap (
      .clk(clk), .reset(reset), .ch_en(ch_en), .event_in(event_in), .clr_all(clr_all),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch),
      .ovf_clr(ovf_clr), .rd_data(rdDataW), .rd_valid(rdValidW), .ovf(ovfW)
`ifdef PERF_COUNTER_SNAPSHOT_EN
      , .snap(snap), .rd_snap(rd_snap)
`endif
   );

   perf_counter_bank #(.WIDTH(8), .NUM_CH(4), .SATURATE(1)) dutSat (
      .clk(clk), .reset(reset), .ch_en(ch_en), .event_in(event_in), .clr_all(clr_all),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .rd_en(rd_en), .rd_ch(rd_ch),
      .ovf_clr(ovf_clr), .rd_data(rdDataS), .rd_valid(rdValidS), .ovf(ovfS)
`ifdef PERF_COUNTER_SNAPSHOT_EN
      , .snap(snap), .rd_snap(rd_snap)
`endif
   );

   task automatic resetModel();
      for (int m = 0; m < 2; m++) begin
         expRd[m] = 0;
         for (int c = 0; c < 4; c++) begin
            mCnt[m][c] = 0;
            mOvf[m][c] = 1'b0;
            mShadow[m][c] = 0;
         end
      end
      expRv = 1'b0;
   endtask

   // Model of one clock edge, built from the counting rules with plain integer arithmetic
   task automatic modelStep();
      for (int m = 0; m < 2; m++) begin
         if (rd_en) expRd[m] = (SNAP_EN && rd_snap) ? mShadow[m][rd_ch] : mCnt[m][rd_ch];
         if (SNAP_EN && snap) for (int c = 0; c < 4; c++) mShadow[m][c] = mCnt[m][c];
         for (int c = 0; c < 4; c++) begin
            bit overflow;
            overflow = 1'b0;
            if (clr_all) begin
               mCnt[m][c] = 0;
               mOvf[m][c] = 1'b0;
               continue;
            end
            if (wr_en && wr_ch == c) begin
               mCnt[m][c] = wr_data;
            end else if (ch_en[c] && event_in[c]) begin
               overflow = (mCnt[m][c] + 1 > MAXV);
               if (m == 0) mCnt[m][c] = (mCnt[m][c] + 1) % (MAXV + 1);
               else        mCnt[m][c] = overflow ? MAXV : mCnt[m][c] + 1;
            end
            mOvf[m][c] = overflow || (mOvf[m][c] && !ovf_clr[c]);
         end
      end
      expRv = rd_en;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   function automatic logic [3:0] ovfVec(input int m);
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = mOvf[m][c];
      return v;
   endfunction

   task automatic checkAll(input string tag);
      checkOutput({tag, "_rdDataW"}, 64'(rdDataW), 64'(expRd[0]));
      checkOutput({tag, "_rdDataS"}, 64'(rdDataS), 64'(expRd[1]));
      checkOutput({tag, "_rdValidW"}, 64'(rdValidW), 64'(expRv));
      checkOutput({tag, "_rdValidS"}, 64'(rdValidS), 64'(expRv));
      checkOutput({tag, "_ovfW"}, 64'(ovfW), 64'(ovfVec(0)));
      checkOutput({tag, "_ovfS"}, 64'(ovfS), 64'(ovfVec(1)));
   endtask

   task automatic idleInputs();
      ch_en = '0; event_in = '0; ovf_clr = '0; clr_all = 1'b0;
      wr_en = 1'b0; wr_ch = '0; wr_data = '0;
      rd_en = 1'b0; rd_ch = '0; snap = 1'b0; rd_snap = 1'b0;
   endtask

   task automatic readCh(input logic [1:0] ch, input bit fromSnap, input string tag);
      rd_en = 1'b1; rd_ch = ch; rd_snap = fromSnap;
      applyStimulus();
      rd_en = 1'b0; rd_snap = 1'b0;
      checkAll(tag);
   endtask

   task automatic preload(input logic [1:0] ch, input logic [7:0] val);
      wr_en = 1'b1; wr_ch = ch; wr_data = val;
      applyStimulus();
      wr_en = 1'b0;
   endtask

   task automatic countEvents(input logic [3:0] mask, input int n);
      ch_en = mask; event_in = mask;
      repeat (n) applyStimulus();
      ch_en = '0; event_in = '0;
   endtask

   initial begin
      idleInputs();
      resetModel();
      reset = 1'b1;
      #12;
      checkAll("reset");
      @(negedge clk);
      reset = 1'b0;

      // Only enabled channels count
      ch_en = 4'b0101; event_in = 4'b1111;
      repeat (10) applyStimulus();
      ch_en = '0; event_in = '0;
      checkOutput("enCount_model_ch0", 64'(mCnt[0][0]), 64'd10);
      for (int c = 0; c < 4; c++) readCh(2'(c), 1'b0, $sformatf("enRead%0d", c));

      // Wrap past all-ones and clear the flag
      preload(2'd1, 8'hFE);
      countEvents(4'b0010, 3);
      readCh(2'd1, 1'b0, "wrapRead");
      checkOutput("wrapValue", 64'(rdDataW), 64'h01);
      checkOutput("satValue", 64'(rdDataS), 64'hFF);
      ovf_clr = 4'b0010;
      applyStimulus();
      ovf_clr = '0;
      checkAll("ovfClr");
      checkOutput("ovfClrBit", 64'(ovfW[1]), 64'd0);

      // Saturate holds at all-ones
      preload(2'd2, 8'hFF);
      countEvents(4'b0100, 2);
      readCh(2'd2, 1'b0, "satRead");
      checkOutput("satOvf", 64'(ovfS[2]), 64'd1);

      // Preload overrides a same-cycle increment; clr_all overrides preload
      wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'h40; ch_en = 4'b0001; event_in = 4'b0001;
      applyStimulus();
      idleInputs();
      readCh(2'd0, 1'b0, "loadVsInc");
      wr_en = 1'b1; wr_data = 8'h40; ch_en = 4'b0001; event_in = 4'b0001; clr_all = 1'b1;
      applyStimulus();
      idleInputs();
      readCh(2'd0, 1'b0, "clrVsLoad");
      checkOutput("clrOvf", 64'(ovfW), 64'd0);

      // Read returns the pre-update value
      preload(2'd3, 8'd5);
      ch_en = 4'b1000; event_in = 4'b1000;
      readCh(2'd3, 1'b0, "readOld");
      ch_en = '0; event_in = '0;
      checkOutput("readOldValue", 64'(rdDataW), 64'd5);
      readCh(2'd3, 1'b0, "readNew");
      checkOutput("readNewValue", 64'(rdDataW), 64'd6);
      applyStimulus();
      checkAll("readHold");

      // Overflow coinciding with its clear keeps the flag
      preload(2'd0, 8'hFF);
      ovf_clr = 4'b0001; ch_en = 4'b0001; event_in = 4'b0001;
      applyStimulus();
      idleInputs();
      checkAll("setWins");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         ch_en    = 4'($urandom);
         event_in = 4'($urandom);
         ovf_clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
         clr_all  = ($urandom_range(0, 40) == 0);
         wr_en    = ($urandom_range(0, 5) == 0);
         wr_ch    = 2'($urandom);
         wr_data  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
         rd_en    = ($urandom_range(0, 1) == 0);
         rd_ch    = 2'($urandom);
         snap     = ($urandom_range(0, 9) == 0);
         rd_snap  = 1'($urandom);
         applyStimulus();
         checkAll($sformatf("rand%0d", i));
      end
      idleInputs();

      // Snapshot keeps the earlier count while live counting continues
      clr_all = 1'b1;
      applyStimulus();
      clr_all = 1'b0;
      countEvents(4'b0001, 7);
      if (SNAP_EN) begin
         snap = 1'b1;
         applyStimulus();
         snap = 1'b0;
         countEvents(4'b0001, 3);
         readCh(2'd0, 1'b1, "snapRead");
         checkOutput("snapValue", 64'(rdDataW), 64'd7);
         readCh(2'd0, 1'b0, "liveRead");
         checkOutput("liveValue", 64'(rdDataW), 64'd10);
         clr_all = 1'b1;
         applyStimulus();
         clr_all = 1'b0;
         countEvents(4'b0001, 7);
      end

      // Reset asserted during an in-flight read
      readCh(2'd0, 1'b0, "preResetRead");
      checkOutput("preResetValue", 64'(rdDataW), 64'd7);
      rd_en = 1'b1; rd_ch = 2'd0;
      #2;
      reset = 1'b1;
      resetModel();
      #1;
      checkAll("asyncReset");
      @(posedge clk);
      #1;
      checkAll("inReset");
      @(negedge clk);
      reset = 1'b0;
      rd_en = 1'b0;
      applyStimulus();
      checkAll("afterReset");
      readCh(2'd0, 1'b0, "postResetRead");

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
